// File: rtl/act_pool.sv
// -----------------------------------------------------------------------------
// act_pool
//
// Activation + requantization + max-pool stage that sits behind the aggregator.
// Each accepted signed sum is optionally ReLU-clamped, arithmetically shifted
// right, saturated to an OUT_W-bit signed activation and folded into a running
// maximum. Every POOL accepted activations produce one pooled output word,
// presented through a single-entry registered valid/ready stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_data      aggregated sum (signed, IN_W bits)
//   in_valid     in_data is valid
//   in_ready     stage accepts in_data this cycle (combinational from out_ready)
//   cfg_relu_en  1 = clamp negative sums to zero before shifting
//   cfg_shift    arithmetic right-shift amount, sampled per element
//   flush        synchronous discard of the partial pooling window
//   out_data     pooled activation (signed, OUT_W bits)
//   out_valid    out_data is valid
//   out_ready    downstream accepts out_data
//   win_cnt      activations accumulated in the current window
// -----------------------------------------------------------------------------
module act_pool #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 8,
   parameter int POOL  = 4,
   parameter int SH_W  = 4,
   localparam int CNT_W = $clog2(POOL) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    cfg_relu_en,
   input  logic [SH_W-1:0]         cfg_shift,
   input  logic                    flush,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        win_cnt
);

   localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(POOL - 1);
   localparam logic signed [IN_W-1:0] SAT_HI   = IN_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [IN_W-1:0] SAT_LO   = IN_W'(-(1 << (OUT_W - 1)));

   // Clamp a shifted sum into the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [IN_W-1:0] v);
      logic signed [OUT_W-1:0] res;
      if (v > SAT_HI) begin
         res = SAT_HI[OUT_W-1:0];
      end else if (v < SAT_LO) begin
         res = SAT_LO[OUT_W-1:0];
      end else begin
         res = v[OUT_W-1:0];
      end
      return res;
   endfunction

   function automatic logic signed [OUT_W-1:0] smax(input logic signed [OUT_W-1:0] a,
                                                   input logic signed [OUT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [CNT_W-1:0]        win_cnt_q,   win_cnt_d;
   logic signed [OUT_W-1:0] max_q,       max_d;
   logic signed [OUT_W-1:0] out_data_q,  out_data_d;
   logic                    out_valid_q, out_valid_d;

   logic                    accept;
   logic signed [IN_W-1:0]  relu_val;
   logic signed [IN_W-1:0]  shift_val;
   logic signed [OUT_W-1:0] act_val;
   logic signed [OUT_W-1:0] pooled;

   // Per-element datapath: ReLU, requantizing shift, saturation
   always_comb begin
      relu_val  = (cfg_relu_en && in_data[IN_W-1]) ? '0 : in_data;
      // >>> on a signed operand floors toward minus infinity
      shift_val = relu_val >>> cfg_shift;
      act_val   = saturate(shift_val);
      // The first element of a window seeds the maximum; it never compares
      // against the stale value left from a previous window.
      pooled    = (win_cnt_q == '0) ? act_val : smax(max_q, act_val);
   end

   // Window accumulation and output handshake
   always_comb begin
      in_ready    = !out_valid_q || out_ready;
      accept      = in_valid && in_ready;

      win_cnt_d   = win_cnt_q;
      max_d       = max_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (flush) begin
         // An element offered alongside flush is accepted and dropped.
         win_cnt_d = '0;
         max_d     = '0;
      end else if (accept) begin
         if (win_cnt_q == LAST_CNT) begin
            // Completing a window overrides a same-cycle drain: no bubble.
            win_cnt_d   = '0;
            max_d       = '0;
            out_data_d  = pooled;
            out_valid_d = 1'b1;
         end else begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
            max_d     = pooled;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt_q   <= '0;
         max_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         win_cnt_q   <= win_cnt_d;
         max_q       <= max_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign win_cnt   = win_cnt_q;

endmodule

// File: tb/tb_act_pool.sv
// -----------------------------------------------------------------------------
// tb_act_pool
//
// Scoreboard bench for act_pool. A negedge monitor mirrors every handshake the
// DUT will perform at the next rising edge: accepted inputs are turned into
// activations by an arithmetic reference model and collected per window; full
// windows push their maximum into an expected-output queue, which is popped
// whenever the DUT transfers an output word.
// -----------------------------------------------------------------------------
module tb_act_pool;

   localparam int IN_W  = 12;
   localparam int OUT_W = 8;
   localparam int POOL  = 4;
   localparam int SH_W  = 4;
   localparam int CNT_W = $clog2(POOL) + 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic signed [IN_W-1:0]  in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic                    cfg_relu_en;
   logic [SH_W-1:0]         cfg_shift;
   logic                    flush;
   logic signed [OUT_W-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [CNT_W-1:0]        win_cnt;

   always #5 clk = ~clk;

   act_pool #(.IN_W(IN_W), .OUT_W(OUT_W), .POOL(POOL), .SH_W(SH_W)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .cfg_relu_en(cfg_relu_en), .cfg_shift(cfg_shift), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .win_cnt(win_cnt)
   );

   int checks = 0;
   int errors = 0;
   int wq[$];
   int expq[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data  = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference activation: floor division by 2^sh, then clamp.
   function automatic int act_of(input int x, input bit relu, input int sh);
      int r, d, s;
      r = (relu && x < 0) ? 0 : x;
      d = 1 << sh;
      if (r >= 0) s = r / d;
      else        s = -((-r + d - 1) / d);
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   function automatic int max_of_window();
      int m;
      m = wq[0];
      foreach (wq[i]) if (wq[i] > m) m = wq[i];
      return m;
   endfunction

   // Monitor + reference model
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         wq.delete();
         expq.delete();
      end else begin
         if (prev_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'($signed(prev_data)));
         end
         chk("win_cnt", int'(win_cnt), wq.size());
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out got %0d expected none at %0t", out_data, $time);
            end else begin
               chk("sb_out_data", int'(out_data), expq.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (flush) begin
            wq.delete();
         end else if (in_valid && in_ready) begin
            wq.push_back(act_of(int'(in_data), cfg_relu_en, int'(cfg_shift)));
            if (wq.size() == POOL) begin
               expq.push_back(max_of_window());
               wq.delete();
            end
         end
      end
   end

   task automatic send(input int data, input bit relu, input int sh);
      in_data     = IN_W'(data);
      cfg_relu_en = relu;
      cfg_shift   = SH_W'(sh);
      in_valid    = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) chk("send_timeout_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input string name, input int exp);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk({name, "_valid"}, int'(out_valid), 1);
      chk(name, int'(out_data), exp);
      @(posedge clk);
      #1;
   endtask

   int basic_in[4]  = '{5, -3, 100, 7};
   int neg_in[4]    = '{-1, -50, -7, -300};

   initial begin
      rst = 1'b1; in_data = '0; in_valid = 1'b0; cfg_relu_en = 1'b0;
      cfg_shift = '0; flush = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_win_cnt", int'(win_cnt), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_in_ready", int'(in_ready), 1);

      // Basic pool with latency and win_cnt sequence
      for (int i = 0; i < 4; i++) begin
         send(basic_in[i], 1'b1, 0);
         chk("basic_win_cnt", int'(win_cnt), (i + 1) % POOL);
      end
      chk("basic_latency_valid", int'(out_valid), 1);
      chk("basic_out_data", int'(out_data), 100);
      @(posedge clk); #1;
      chk("basic_pulse_clears", int'(out_valid), 0);

      // Saturation and shift
      for (int i = 0; i < 4; i++) send(-2048, 1'b0, 0);
      wait_out("sat_neg", -128);
      send(1024, 1'b0, 4); send(-1, 1'b0, 0); send(-5, 1'b0, 0); send(-2048, 1'b0, 0);
      wait_out("shift4", 64);
      send(2047, 1'b0, 0); send(-2048, 1'b0, 0); send(1024, 1'b0, 0); send(-1, 1'b0, 0);
      wait_out("sat_window", 127);
      send(1024, 1'b0, 4); send(2047, 1'b0, 2); send(1024, 1'b0, 4); send(-9, 1'b0, 1);
      wait_out("sat_shift2", 127);

      // All-negative windows with and without ReLU
      for (int i = 0; i < 4; i++) send(neg_in[i], 1'b0, 0);
      wait_out("all_neg", -1);
      for (int i = 0; i < 4; i++) send(neg_in[i], 1'b1, 0);
      wait_out("all_neg_relu", 0);

      // Backpressure: stalled output blocks input and freezes the window
      out_ready = 1'b0;
      send(10, 1'b1, 0); send(20, 1'b1, 0); send(40, 1'b1, 0); send(30, 1'b1, 0);
      in_data = 12'sd11; in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_data", int'(out_data), 40);
         chk("bp_win_cnt", int'(win_cnt), 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(11, 1'b1, 0); send(12, 1'b1, 0); send(14, 1'b1, 0); send(13, 1'b1, 0);
      wait_out("bp_second", 14);

      // Back-to-back windows at full rate
      for (int i = 0; i < 8; i++) send(i * 3 - 4, 1'b0, 0);
      wait_out("b2b_second", 17);

      // Flush and gaps
      send(9, 1'b1, 0); send(3, 1'b1, 0);
      in_data = 12'sd99; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_win_cnt", int'(win_cnt), 0);
      send(1, 1'b1, 0); idle(2);
      send(2, 1'b1, 0); idle(3);
      send(4, 1'b1, 0); idle(1);
      send(8, 1'b1, 0);
      wait_out("flush_gaps", 8);

      // Asynchronous reset mid-window
      send(100, 1'b0, 0); send(50, 1'b0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_win_cnt", int'(win_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("arst_in_ready", int'(in_ready), 1);
      send(1, 1'b0, 0); send(2, 1'b0, 0); send(3, 1'b0, 0); send(4, 1'b0, 0);
      wait_out("after_reset", 4);

      // Randomized traffic against the scoreboard
      repeat (3000) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0:       in_data = 12'sh7FF;
            1:       in_data = 12'sh800;
            default: in_data = IN_W'($urandom);
         endcase
         cfg_relu_en = 1'($urandom);
         cfg_shift   = SH_W'($urandom_range(0, 15));
         flush       = ($urandom_range(0, 31) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      idle(5);
      chk("drain_empty", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/act_pool.md
Name: act_pool

Overview:
- Downstream consumer of the aggregator stage. Takes each 12-bit signed aggregated sum and applies optional ReLU.
- Requantizes the result with an arithmetic right shift and saturates it to an 8-bit signed activation.
- Max-pools POOL consecutive activations into one output word.
- Output side is a single-entry registered valid/ready stage feeding the next layer buffer.

Parameters:
- IN_W, 12, width of aggregated input sample (signed two's complement).
- OUT_W, 8, width of pooled activation output (signed two's complement).
- POOL, 4, activations per pooling window; legal range 1..16.
- SH_W, 4, width of requantization shift control.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  IN_W  aggregated sum, signed.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- cfg_relu_en  input  1  1 = clamp negative sums to 0 before shifting.
- cfg_shift  input  SH_W  arithmetic right-shift amount, 0..15.
- flush  input  1  synchronous discard of the partial window.
- out_data  output  OUT_W  pooled activation, signed.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- win_cnt  output  clog2(POOL)+1  activations accumulated in the current window.

Behaviour:
- Reset, async, on rst=1:
  - win_cnt=0, running max=0.
  - out_data=0, out_valid=0.
  - in_ready=1 on the first cycle after release.
- Accept: in_valid & in_ready at the rising edge. in_ready = !out_valid | out_ready, combinational from out_ready.
- Per-element datapath, combinational on the accept cycle, config sampled per element:
  - Step 1: r = (cfg_relu_en & in_data<0) ? 0 : in_data.
  - Step 2: s = r >>> cfg_shift, sign-extending and truncating toward minus infinity.
  - Step 3: a = saturate(s) to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128, 127] at default.
- Pool counter win_cnt:
  - Accept with win_cnt==0: max<=a.
  - Accept with 0<win_cnt<POOL-1: max<=max(max,a), signed compare.
  - Accept with win_cnt==POOL-1: out_data<=max(max,a), out_valid<=1, win_cnt<=0.
  - Otherwise win_cnt increments by 1 on each accept.
  - POOL=1: every accepted element is emitted directly (out_data<=a).
- Latency: out_valid asserts on the edge that accepts the POOL-th element, visible the following cycle.
- Output handshake:
  - out_data and out_valid are registered.
  - out_data is held stable while out_valid & !out_ready.
  - out_valid clears on out_ready unless a new window completes in the same cycle. In that case out_data updates and out_valid stays 1 (back-to-back, no bubble).
- Backpressure: out_valid & !out_ready forces in_ready=0. The partial window state holds and no element is lost.
- flush:
  - Sets win_cnt=0 and max=0 in the next cycle.
  - An in_valid element in the flush cycle is accepted and dropped.
  - The output register is unaffected.
- Gaps: in_valid may deassert mid-window for any number of cycles; the window resumes.
- Reset mid-window: all state cleared, the partial window is lost, and a pending output is dropped.

Test Plan:
- Basic pool, POOL=4, relu=1, shift=0: in 5, -3, 100, 7 on consecutive cycles -> one out_data=100, out_valid high exactly 1 cycle after the 4th accept with out_ready=1; win_cnt sequence 0,1,2,3,0.
- Saturation and shift, relu=0:
  - in 2047, shift=2 -> a=127.
  - in -2048, shift=0 -> a=-128.
  - in 1024, shift=4 -> a=64.
  - Window {2047,-2048,1024,-1} at shift 0 -> out 127.
- All-negative window, relu=0, shift=0: in -1, -50, -7, -300 -> out_data=-1; same inputs with relu=1 -> out_data=0.
- Backpressure: out_ready=0 after the first window completes; 4 more valid inputs -> in_ready=0, out_data held at the first result, win_cnt frozen at 0. Raise out_ready -> first result consumed, second window then completes with no data loss. Also check the back-to-back window case.
- Flush and gaps: in 9, 3, then flush, then 1, 2, 4, 8 with idle cycles between -> out_data=8; 9 never appears.
- Reset mid-window: in 100, 50, assert rst async mid-cycle -> out_valid=0, win_cnt=0 immediately. After release, in 1, 2, 3, 4 -> out_data=4.
